// File: rtl/bp_be_pkg.sv
// Shared definitions for the backend FMA/IMUL writeback pipe.
package bp_be_pkg;

  // Writeback channel select as presented on issue_ch_i
  typedef enum logic {
    e_wb_imul = 1'b0,
    e_wb_fma  = 1'b1
  } bp_be_wb_ch_e;

  // RISC-V floating-point exception flag width (NV, DZ, OF, UF, NX)
  localparam int fflags_width_gp = 5;

endpackage

// File: rtl/bp_be_fma_wb_channel.sv
// One writeback channel: a valid/tag shift chain that tracks ops through the
// datapath, a FIFO writeback buffer fed when an op reaches the end of the chain,
// and a credit counter that reserves a buffer slot for every op in flight.
module bp_be_fma_wb_channel
  import bp_be_pkg::*;
#(
  parameter int data_width_p = 64,
  parameter int latency_p    = 3,
  parameter int els_p        = 4,
  parameter int tag_width_p  = 5
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    flush_i,
  input  logic                    accept_i,
  input  logic [tag_width_p-1:0]  tag_i,
  input  logic [data_width_p-1:0] core_data_i,
  input  logic                    yumi_i,
  output logic                    ready_o,
  output logic                    v_o,
  output logic [data_width_p-1:0] data_o,
  output logic [tag_width_p-1:0]  tag_o
);

  localparam int aw_lp = $clog2(els_p);
  localparam logic [aw_lp:0] els_lp = els_p[aw_lp:0];
  localparam logic [aw_lp:0] one_lp = {{aw_lp{1'b0}}, 1'b1};

  // Chain stage i holds an op accepted i+1 cycles ago; the last stage lines up
  // with the cycle in which the datapath presents that op's result.
  logic [latency_p-2:0]   vld_p;
  logic [tag_width_p-1:0] tag_p [latency_p-1];

  logic [aw_lp:0]         credit_r;
  logic [aw_lp:0]         wptr_r, rptr_r;
  logic [data_width_p-1:0] data_mem [els_p];
  logic [tag_width_p-1:0]  tag_mem  [els_p];

  logic wr_en, empty, full;

  assign wr_en = vld_p[latency_p-2];
  assign empty = (wptr_r == rptr_r);
  assign full  = (wptr_r[aw_lp] != rptr_r[aw_lp])
              && (wptr_r[aw_lp-1:0] == rptr_r[aw_lp-1:0]);

  assign v_o     = !empty;
  assign data_o  = data_mem[rptr_r[aw_lp-1:0]];
  assign tag_o   = tag_mem[rptr_r[aw_lp-1:0]];
  assign ready_o = (credit_r < els_lp);

  // Issue -> chain stage 0 -> ... -> last stage: valid bits, killed by flush
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      vld_p <= '0;
    end else if (flush_i) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= accept_i;
      for (int i = 1; i < latency_p - 1; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // Tag chain follows the valid chain; contents are don't-care when invalid
  always_ff @(posedge clk_i) begin
    tag_p[0] <= tag_i;
    for (int i = 1; i < latency_p - 1; i++) tag_p[i] <= tag_p[i-1];
  end

  // Credits = ops in flight + buffered entries; a slot is reserved at issue
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      credit_r <= '0;
    end else if (flush_i) begin
      credit_r <= '0;
    end else if (accept_i && !yumi_i) begin
      credit_r <= credit_r + one_lp;
    end else if (!accept_i && yumi_i) begin
      credit_r <= credit_r - one_lp;
    end
  end

  // Buffer pointers carry one extra bit so full and empty are distinct
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
    end else if (flush_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
    end else begin
      if (wr_en)  wptr_r <= wptr_r + one_lp;
      if (yumi_i) rptr_r <= rptr_r + one_lp;
    end
  end

  // Last chain stage -> buffer: capture the datapath result with its tag
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      data_mem[wptr_r[aw_lp-1:0]] <= core_data_i;
      tag_mem[wptr_r[aw_lp-1:0]]  <= tag_p[latency_p-2];
    end
  end

  // Consumer may only pop a non-empty buffer
  assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);

  // A write into a full buffer is only safe when the head leaves in the same cycle
  assert property (@(posedge clk_i) disable iff (!reset_n_i) (wr_en && full) |-> yumi_i);

endmodule

// File: rtl/bp_be_pipe_fma_wb.sv
// Writeback collection for the shared FMA/IMUL datapath: routes issued ops to
// the imul or fma channel, buffers results in issue order per channel, and
// accumulates the floating-point exception flags of consumed fma results.
module bp_be_pipe_fma_wb
  import bp_be_pkg::*;
#(
  parameter int data_width_p   = 65,
  parameter int imul_latency_p = 3,
  parameter int fma_latency_p  = 4,
  parameter int wb_els_p       = 4,
  parameter int tag_width_p    = 5
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       issue_v_i,
  input  logic                       issue_ch_i,
  input  logic [tag_width_p-1:0]     issue_tag_i,
  output logic [1:0]                 issue_ready_o,
  input  logic                       flush_i,
  input  logic [63:0]                core_imul_data_i,
  input  logic [data_width_p-1:0]    core_fma_data_i,
  input  logic [fflags_width_gp-1:0] core_fma_fflags_i,
  output logic                       imul_v_o,
  output logic [63:0]                imul_data_o,
  output logic [tag_width_p-1:0]     imul_tag_o,
  input  logic                       imul_yumi_i,
  output logic                       fma_v_o,
  output logic [data_width_p-1:0]    fma_data_o,
  output logic [fflags_width_gp-1:0] fma_fflags_o,
  output logic [tag_width_p-1:0]     fma_tag_o,
  input  logic                       fma_yumi_i,
  output logic [fflags_width_gp-1:0] fflags_acc_o,
  input  logic                       fflags_clr_i
);

  localparam int fma_entry_w_lp = data_width_p + fflags_width_gp;

  bp_be_wb_ch_e ch;
  logic         issue_go;
  logic         imul_accept, fma_accept;
  logic [fma_entry_w_lp-1:0] fma_core_entry, fma_head_entry;

  assign ch          = bp_be_wb_ch_e'(issue_ch_i);
  assign issue_go    = issue_v_i && !flush_i;
  assign imul_accept = issue_go && (ch == e_wb_imul) && issue_ready_o[0];
  assign fma_accept  = issue_go && (ch == e_wb_fma)  && issue_ready_o[1];

  // Flags travel with the fma result as the upper field of one buffer entry
  assign fma_core_entry = {core_fma_fflags_i, core_fma_data_i};
  assign fma_fflags_o   = fma_head_entry[fma_entry_w_lp-1 -: fflags_width_gp];
  assign fma_data_o     = fma_head_entry[data_width_p-1:0];

  bp_be_fma_wb_channel #(
    .data_width_p (64),
    .latency_p    (imul_latency_p),
    .els_p        (wb_els_p),
    .tag_width_p  (tag_width_p)
  ) imul_ch (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .flush_i     (flush_i),
    .accept_i    (imul_accept),
    .tag_i       (issue_tag_i),
    .core_data_i (core_imul_data_i),
    .yumi_i      (imul_yumi_i),
    .ready_o     (issue_ready_o[0]),
    .v_o         (imul_v_o),
    .data_o      (imul_data_o),
    .tag_o       (imul_tag_o)
  );

  bp_be_fma_wb_channel #(
    .data_width_p (fma_entry_w_lp),
    .latency_p    (fma_latency_p),
    .els_p        (wb_els_p),
    .tag_width_p  (tag_width_p)
  ) fma_ch (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .flush_i     (flush_i),
    .accept_i    (fma_accept),
    .tag_i       (issue_tag_i),
    .core_data_i (fma_core_entry),
    .yumi_i      (fma_yumi_i),
    .ready_o     (issue_ready_o[1]),
    .v_o         (fma_v_o),
    .data_o      (fma_head_entry),
    .tag_o       (fma_tag_o)
  );

  // Sticky flag accumulation; a clear coinciding with a pop keeps only that pop
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      fflags_acc_o <= '0;
    end else if (fflags_clr_i) begin
      fflags_acc_o <= fma_yumi_i ? fma_fflags_o : '0;
    end else if (fma_yumi_i) begin
      fflags_acc_o <= fflags_acc_o | fma_fflags_o;
    end
  end

endmodule
